// File: rtl/uart_tx_ser.sv
// UART transmit serialiser: byte holding register feeding a start/data/parity/stop
// frame generator with a registered, glitch-free serial output.
module uart_tx_ser #(
  parameter int unsigned CLKS_PER_BIT = 48,
  parameter bit          PARITY_EN    = 1'b1,
  parameter bit          PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] PalDataIn,
  input  logic       PalDataInEn,
  output logic       PalDataInPermit,
  output logic       SerDataOut,
  output logic       TxBusy,
  output logic       TxOverrun
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t     state, stateNext;
  logic [CNT_W-1:0] bCnt, bCntNext;
  logic [2:0] bitN, bitNNext;
  logic [7:0] shReg, shRegNext;
  logic [7:0] hold, holdNext;
  logic       holdFull, holdFullNext;
  logic       par, parNext;
  logic       serNext;
  logic       overrunNext;
  logic       bitEnd;
  logic       writeOk;
  logic       load;
  logic [7:0] loadData;

  assign PalDataInPermit = ~holdFull;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bCnt       <= '0;
      bitN       <= '0;
      shReg      <= '0;
      hold       <= '0;
      holdFull   <= 1'b0;
      par        <= 1'b0;
      SerDataOut <= 1'b1;
      TxBusy     <= 1'b0;
      TxOverrun  <= 1'b0;
    end else begin
      state      <= stateNext;
      bCnt       <= bCntNext;
      bitN       <= bitNNext;
      shReg      <= shRegNext;
      hold       <= holdNext;
      holdFull   <= holdFullNext;
      par        <= parNext;
      SerDataOut <= serNext;
      TxBusy     <= (stateNext != IDLE);
      TxOverrun  <= overrunNext;
    end
  end

  always_comb begin
    bitEnd       = (bCnt == LAST_CNT);
    writeOk      = PalDataInEn & ~holdFull;
    stateNext    = state;
    bCntNext     = bitEnd ? '0 : CNT_W'(bCnt + 1'b1);
    bitNNext     = bitN;
    shRegNext    = shReg;
    parNext      = par;
    holdNext     = writeOk ? PalDataIn : hold;
    holdFullNext = holdFull | writeOk;
    overrunNext  = TxOverrun | (PalDataInEn & holdFull);
    load         = 1'b0;
    // A byte written on the final stop edge is loaded straight from the bus.
    loadData     = holdFull ? hold : PalDataIn;

    case (state)
      IDLE: begin
        bCntNext = '0;
        if (holdFull) load = 1'b1;
      end
      START: begin
        if (bitEnd) begin
          stateNext = DATA;
          bitNNext  = 3'd0;
        end
      end
      DATA: begin
        if (bitEnd) begin
          shRegNext = {1'b0, shReg[7:1]};
          if (bitN == 3'd7) stateNext = PARITY_EN ? PARITY : STOP;
          else              bitNNext  = 3'(bitN + 3'd1);
        end
      end
      PARITY: begin
        if (bitEnd) stateNext = STOP;
      end
      STOP: begin
        if (bitEnd) begin
          if (holdFull || writeOk) load = 1'b1;
          else                     stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase

    if (load) begin
      stateNext    = START;
      shRegNext    = loadData;
      parNext      = (^loadData) ^ PARITY_ODD;
      holdFullNext = 1'b0;
      bCntNext     = '0;
    end

    // Line level follows the state being entered, so it only moves on bit boundaries.
    case (stateNext)
      START:   serNext = 1'b0;
      DATA:    serNext = shRegNext[0];
      PARITY:  serNext = parNext;
      default: serNext = 1'b1;
    endcase
  end

endmodule
